// File: rtl/core_run_ctrl_if.sv
// rtl/core_run_ctrl_if.sv - store port, retire strobe and console byte stream for core_run_ctrl
interface core_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              retire;
  logic              con_valid;
  logic [7:0]        con_data;
  logic              con_ready;

  // core/bench side: issues stores and retire pulses, consumes console bytes
  modport master (
    output st_valid, st_addr, st_data, retire, con_ready,
    input  con_valid, con_data
  );

  // run controller side
  modport slave (
    input  st_valid, st_addr, st_data, retire, con_ready,
    output con_valid, con_data
  );
endinterface

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - core reset sequencing, cycle/instret counting, tohost pass/fail/timeout and console FIFO
module core_run_ctrl #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 90,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_0100,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = 32'h0000_0104,
  parameter int                FIFO_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  core_run_ctrl_if.slave    bus,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt,
  output logic              con_ovf
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic              TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    TMO  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [HOLD_W-1:0] hold_cnt;

  logic              in_run;
  logic              tohost_wr;
  logic              console_wr;
  logic              tmo_hit;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign in_run     = (state == RUN);
  assign tohost_wr  = in_run && bus.st_valid && (bus.st_addr == TOHOST_ADDR);
  assign console_wr = in_run && bus.st_valid && (bus.st_addr == CONSOLE_ADDR);
  assign tmo_hit    = TMO_EN && in_run && (cycle_cnt == TMO_LAST);

  // A full FIFO still accepts a push when the head is popped on the same edge
  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign pop       = bus.con_valid && bus.con_ready;
  assign push      = console_wr && (!fifo_full || pop);

  assign bus.con_valid = (fifo_cnt != '0);
  assign bus.con_data  = fifo_mem[rd_ptr];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: hold the core in reset, then run until a tohost verdict or timeout
  always_comb begin
    state_next = state;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A terminating store takes priority over a coincident timeout
        if (tohost_wr && (bus.st_data == DATA_W'(1))) begin
          state_next = PASS;
        end else if (tohost_wr && bus.st_data[0]) begin
          state_next = FAIL;
        end else if (tmo_hit) begin
          state_next = TMO;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // Reset-hold counter, only meaningful while in HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if ((state == HOLD) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else begin
      core_rst <= (state_next != RUN);
      running  <= (state_next == RUN);
      done     <= (state_next == PASS) || (state_next == FAIL) || (state_next == TMO);
      pass     <= (state_next == PASS);
      timeout  <= (state_next == TMO);
      if (in_run && (state_next == FAIL)) begin
        fail_code <= bus.st_data[DATA_W-1:1];
      end
    end
  end

  // Saturating cycle and retired-instruction counters, live only in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (in_run) begin
      if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (bus.retire && (instret_cnt != '1)) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

  // Console FIFO storage and pointers; drains in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.st_data[7:0];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky flag for a console byte lost to a full FIFO with no pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      con_ovf <= 1'b0;
    end else if (console_wr && fifo_full && !pop) begin
      con_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl
module tb_core_run_ctrl;

  localparam int RC  = 4;
  localparam int TMO = 90;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_rst, running, done, pass, timeout, con_ovf;
  logic [30:0] fail_code;
  logic [31:0] cycle_cnt, instret_cnt;

  int tests = 0;
  int fails = 0;

  core_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  core_run_ctrl #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(32), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TMO),
    .TOHOST_ADDR(32'h0000_0100), .CONSOLE_ADDR(32'h0000_0104), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .core_rst(core_rst),
    .running(running),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_code(fail_code),
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt),
    .con_ovf(con_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        retire;
    logic        e_core_rst;
    logic        e_running;
    logic        e_done;
    logic        e_pass;
    logic [31:0] e_cycle;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic rt, input logic ecr, input logic ern, input logic edn,
                              input logic eps, input logic [31:0] ecy, input logic [31:0] eir);
    vec_t v;
    v.st_valid = sv; v.st_addr = sa; v.st_data = sd; v.retire = rt;
    v.e_core_rst = ecr; v.e_running = ern; v.e_done = edn; v.e_pass = eps;
    v.e_cycle = ecy; v.e_instret = eir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.retire   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    bus.con_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic to_run();
    do_reset();
    repeat (RC) tick();
    check("to_run_core_rst", 32'(core_rst), 32'd0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    tick();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Pass scenario table: HOLD for RC edges, 10 retires, tohost=1, then frozen
    for (int i = 0; i < 3; i++) vecs[i] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 4; i < 14; i++) vecs[i] = mk(0, 0, 0, 1, 0, 1, 0, 0, 32'(i - 3), 32'(i - 3));
    vecs[8]  = mk(1, 32'h100, 32'h2, 1, 0, 1, 0, 0, 5, 5);
    vecs[10] = mk(1, 32'h108, 32'h1, 1, 0, 1, 0, 0, 7, 7);
    vecs[14] = mk(1, 32'h100, 32'h1, 0, 1, 0, 1, 1, 11, 10);
    vecs[15] = mk(1, 32'h100, 32'h7, 1, 1, 0, 1, 1, 11, 10);
    vecs[16] = mk(1, 32'h104, 32'h41, 1, 1, 0, 1, 1, 11, 10);

    do_reset();
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_con_valid", 32'(bus.con_valid), 32'd0);

    for (int i = 0; i < 17; i++) begin
      bus.st_valid = vecs[i].st_valid;
      bus.st_addr  = vecs[i].st_addr;
      bus.st_data  = vecs[i].st_data;
      bus.retire   = vecs[i].retire;
      tick();
      check($sformatf("v%0d_core_rst", i), 32'(core_rst), 32'(vecs[i].e_core_rst));
      check($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].e_running));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].e_pass));
      check($sformatf("v%0d_cycle", i), cycle_cnt, vecs[i].e_cycle);
      check($sformatf("v%0d_instret", i), instret_cnt, vecs[i].e_instret);
    end
    idle();
    check("pass_timeout", 32'(timeout), 32'd0);
    check("pass_fail_code", 32'(fail_code), 32'd0);
    check("term_console_ignored", 32'(bus.con_valid), 32'd0);

    // Fail: even tohost ignored, odd non-one fails with code data>>1
    to_run();
    store(32'h100, 32'h2);
    check("fail_even_done", 32'(done), 32'd0);
    check("fail_even_running", 32'(running), 32'd1);
    store(32'h100, 32'h7);
    check("fail_done", 32'(done), 32'd1);
    check("fail_pass", 32'(pass), 32'd0);
    check("fail_timeout", 32'(timeout), 32'd0);
    check("fail_code", 32'(fail_code), 32'd3);
    check("fail_core_rst", 32'(core_rst), 32'd1);
    check("fail_cycle", cycle_cnt, 32'd2);

    // Timeout with no stores
    to_run();
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("tmo_edges", 32'(n), 32'd90);
    check("tmo_timeout", 32'(timeout), 32'd1);
    check("tmo_pass", 32'(pass), 32'd0);
    check("tmo_cycle", cycle_cnt, 32'd90);
    check("tmo_core_rst", 32'(core_rst), 32'd1);

    // Pass store in the timeout cycle wins
    to_run();
    repeat (TMO - 1) tick();
    check("coin_pre_done", 32'(done), 32'd0);
    check("coin_pre_cycle", cycle_cnt, 32'd89);
    store(32'h100, 32'h1);
    check("coin_pass", 32'(pass), 32'd1);
    check("coin_timeout", 32'(timeout), 32'd0);
    check("coin_cycle", cycle_cnt, 32'd90);

    // Console overflow and in-order drain
    to_run();
    for (int i = 0; i < 9; i++) begin
      store(32'h104, 32'h41 + 32'(i));
      if (i == 0) check("con_valid_after_push", 32'(bus.con_valid), 32'd1);
      if (i == 7) check("con_ovf_at_full", 32'(con_ovf), 32'd0);
    end
    check("con_ovf_set", 32'(con_ovf), 32'd1);
    bus.con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(bus.con_valid), 32'd1);
      check($sformatf("drain%0d_data", i), 32'(bus.con_data), 32'h41 + 32'(i));
      tick();
    end
    check("drain_empty", 32'(bus.con_valid), 32'd0);
    check("drain_ovf_sticky", 32'(con_ovf), 32'd1);

    // Push and pop together on a full FIFO: no drop
    to_run();
    for (int i = 0; i < 8; i++) store(32'h104, 32'h61 + 32'(i));
    check("full_ovf_clear", 32'(con_ovf), 32'd0);
    check("full_head", 32'(bus.con_data), 32'h61);
    bus.con_ready = 1'b1;
    store(32'h104, 32'h69);
    check("pushpop_ovf", 32'(con_ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp%0d_data", i), 32'(bus.con_data), 32'h62 + 32'(i));
      tick();
    end
    check("pp_empty", 32'(bus.con_valid), 32'd0);

    // Asynchronous reset between edges mid-run
    to_run();
    bus.retire = 1'b1;
    store(32'h104, 32'h5a);
    bus.retire = 1'b1;
    tick();
    idle();
    check("async_pre_valid", 32'(bus.con_valid), 32'd1);
    check("async_pre_instret", instret_cnt, 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check("async_core_rst", 32'(core_rst), 32'd1);
    check("async_running", 32'(running), 32'd0);
    check("async_cycle", cycle_cnt, 32'd0);
    check("async_instret", instret_cnt, 32'd0);
    check("async_con_valid", 32'(bus.con_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller that sits between the bench (or board) and the pipelined RV32IMF core. It sequences the core's reset and counts cycles and retired instructions. It watches the core's data-memory store port for tohost/console writes and declares pass, fail or timeout. It replaces hard-coded reset/finish delays with a parametrised, cycle-exact completion mechanism and buffers console bytes in a FIFO.

## Interface
Parameters:
- ADDR_W, 32, store-address width
- DATA_W, 32, store-data width (≥ 8)
- CNT_W, 32, width of cycle/instret counters
- RESET_CYCLES, 4, cycles core_rst is held after external reset releases (≥ 1)
- TIMEOUT_CYCLES, 90, RUN cycles before timeout (0 disables timeout)
- TOHOST_ADDR, 32'h0000_0100, pass/fail mailbox address
- CONSOLE_ADDR, 32'h0000_0104, console byte address
- FIFO_DEPTH, 8, console FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- st_valid  in  1  core performs a data-memory store this cycle
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- retire  in  1  one instruction retired this cycle
- core_rst  out  1  active-high reset to the core
- running  out  1  high in RUN
- done  out  1  sticky: run finished (pass, fail or timeout)
- pass  out  1  sticky: tohost wrote 1
- timeout  out  1  sticky: TIMEOUT_CYCLES elapsed in RUN
- fail_code  out  DATA_W-1  st_data>>1 of the failing tohost write, else 0
- cycle_cnt  out  CNT_W  clocks spent in RUN
- instret_cnt  out  CNT_W  retire pulses counted in RUN
- con_valid  out  1  console FIFO non-empty
- con_data  out  8  FIFO head byte
- con_ready  in  1  consumer pops head when con_valid & con_ready
- con_ovf  out  1  sticky: console byte dropped on full FIFO

## Operation
- States: HOLD, RUN, PASS, FAIL, TMO.
- rst low (async): state HOLD, core_rst=1, all counters/flags/FIFO cleared, con_valid=0, fail_code=0.
- HOLD: hold counter increments each clk; when it reaches RESET_CYCLES-1, go to RUN next edge; core_rst=1 throughout HOLD.
- RUN: core_rst=0, running=1; cycle_cnt +1 every clk; instret_cnt +1 per retire. Both saturate at all-ones.
- Store to TOHOST_ADDR in RUN (exact full-width address match):
  - st_data==1 → PASS.
  - st_data odd and ≠1 → FAIL, latch fail_code.
  - st_data even (including 0) → ignored.
- Store to CONSOLE_ADDR in RUN: push st_data[7:0]. If FIFO full and no pop in the same cycle, drop the byte and set con_ovf.
- Timeout: if TIMEOUT_CYCLES≠0 and cycle_cnt==TIMEOUT_CYCLES-1 while in RUN with no terminating store → TMO.
- Simultaneous terminating store and timeout condition: store wins (PASS/FAIL).
- PASS/FAIL/TMO: terminal until rst.
  - done=1; pass=1 only in PASS; timeout=1 only in TMO.
  - core_rst is reasserted (1) to freeze the core.
  - Counters freeze; stores and retire are ignored.
  - FIFO may still drain.
- Stores and retire outside RUN are ignored.
- FIFO: push and pop in the same cycle on a full FIFO are both accepted; on an empty FIFO only the push occurs (no bypass, so con_valid rises the cycle after the push). Pointers wrap modulo FIFO_DEPTH.

## Timing
- All outputs are registered.
- core_rst falls exactly RESET_CYCLES clocks after the first rising edge with rst high.
- RUN→terminal state takes 1 clk: done/pass/timeout/fail_code are visible the cycle after the qualifying store, and core_rst=1 from that same cycle.
- cycle_cnt in a terminal state equals the number of RUN cycles, including the terminating cycle.
- Console push: con_valid=1 one clk after the store. Pop takes effect on the edge where con_valid&con_ready; the next entry appears the same edge.
- rst asserted mid-run: everything returns to reset values immediately (async), with no clk needed.

## Test plan
- Reset sequencing, RESET_CYCLES=4: release rst → core_rst high for exactly 4 edges, then running=1, cycle_cnt counts 1,2,3…
- Pass: 10 retire pulses, then store 32'h1 to 0x100 → next cycle done=1, pass=1, instret_cnt=10, core_rst=1; later stores leave counters unchanged.
- Fail: store 32'h0000_0007 to 0x100 → done=1, pass=0, fail_code=3. Store 32'h2 beforehand → no effect.
- Timeout, TIMEOUT_CYCLES=90, no stores → timeout=1 and done=1 after 90 RUN cycles, cycle_cnt=90. Timeout cycle coinciding with a tohost 1 store → pass=1, timeout=0.
- Console: 9 stores 'A'..'I' to 0x104 with con_ready=0, FIFO_DEPTH=8 → con_ovf=1; draining yields 'A'..'H' in order, then con_valid=0. Simultaneous push/pop when full → no overflow.
- Async reset mid-RUN: drop rst between clk edges → core_rst=1, counters=0, FIFO empty, with no clk edge required.
